regwr_port_arbiter: RTL



---
 rtl/rf_ctrl_pkg.sv | 22 ++
 rtl/regwr_rr_select.sv | 50 +++++
 rtl/regwr_port_arbiter.sv | 135 +++++++++++++
 3 files changed

// File: rtl/rf_ctrl_pkg.sv
// rf_ctrl_pkg: shared constants and types for the register-file write path.
// Holds the default sizing used by the write-port arbiter and the
// write-port record that the register-file wrappers consume.
package rf_ctrl_pkg;

    localparam int NUM_REQ      = 8;
    localparam int NUM_WR_PORTS = 6;
    localparam int SRAM_INDEX   = 6;
    localparam int SRAM_WIDTH   = 32;

    typedef struct packed {
        logic                  we;
        logic [SRAM_INDEX-1:0] addr;
        logic [SRAM_WIDTH-1:0] data;
    } wr_port_t;

    // Increment an index and wrap it back to 0 at the modulus.
    function automatic int wrap_inc(input int idx, input int modulus);
        return (idx + 1 >= modulus) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/regwr_rr_select.sv
// regwr_rr_select: combinational rotate-and-select-first-N.
// Scans requesters starting at ptr, grants the first NUM_WR_PORTS valid ones,
// reports which requester landed on each port and the last one granted.
module regwr_rr_select
    import rf_ctrl_pkg::*;
#(
    parameter int  NUM_REQ      = rf_ctrl_pkg::NUM_REQ,
    parameter int  NUM_WR_PORTS = rf_ctrl_pkg::NUM_WR_PORTS,
    localparam int PTR_W        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0]      valid,
    input  logic [PTR_W-1:0]        ptr,
    output logic [NUM_REQ-1:0]      grant,
    output logic [PTR_W-1:0]        port_idx [NUM_WR_PORTS],
    output logic [NUM_WR_PORTS-1:0] port_used,
    output logic [PTR_W-1:0]        last_idx,
    output logic                    any_grant
);

    int cnt;

    // Walk scan positions in rotated order and hand out ports in that order.
    always_comb begin
        grant     = '0;
        port_used = '0;
        last_idx  = ptr;
        any_grant = 1'b0;
        cnt       = 0;
        for (int k = 0; k < NUM_WR_PORTS; k++) begin
            port_idx[k] = '0;
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            for (int r = 0; r < NUM_REQ; r++) begin
                if ((r == (int'(ptr) + i) % NUM_REQ) && valid[r] && (cnt < NUM_WR_PORTS)) begin
                    grant[r] = 1'b1;
                    for (int k = 0; k < NUM_WR_PORTS; k++) begin
                        if (k == cnt) begin
                            port_idx[k]  = PTR_W'(r);
                            port_used[k] = 1'b1;
                        end
                    end
                    last_idx  = PTR_W'(r);
                    any_grant = 1'b1;
                    cnt       = cnt + 1;
                end
            end
        end
    end

endmodule

// File: rtl/regwr_port_arbiter.sv
// regwr_port_arbiter: shares the register-file write ports among writeback
// sources with a rotating round-robin pointer and a registered output stage.
// Optional feature macro RFWR_CONFLICT_CHECK_EN: suppress same-address
// duplicates within one scan (earlier requester wins) and pulse conflict_o.
module regwr_port_arbiter
    import rf_ctrl_pkg::*;
#(
    parameter int  NUM_REQ      = rf_ctrl_pkg::NUM_REQ,
    parameter int  NUM_WR_PORTS = rf_ctrl_pkg::NUM_WR_PORTS,
    parameter int  SRAM_INDEX   = rf_ctrl_pkg::SRAM_INDEX,
    parameter int  SRAM_WIDTH   = rf_ctrl_pkg::SRAM_WIDTH,
    localparam int PTR_W        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               stall_i,
    input  logic [NUM_REQ-1:0]                 req_valid_i,
    input  logic [NUM_REQ*SRAM_INDEX-1:0]      req_addr_i,
    input  logic [NUM_REQ*SRAM_WIDTH-1:0]      req_data_i,
    output logic [NUM_REQ-1:0]                 req_ready_o,
    output logic [NUM_WR_PORTS-1:0]            we_o,
    output logic [NUM_WR_PORTS*SRAM_INDEX-1:0] addrwr_o,
    output logic [NUM_WR_PORTS*SRAM_WIDTH-1:0] datawr_o,
    output logic                               conflict_o
);

    logic [PTR_W-1:0]        ptr;
    logic [SRAM_INDEX-1:0]   req_addr [NUM_REQ];
    logic [SRAM_WIDTH-1:0]   req_data [NUM_REQ];
    logic [NUM_REQ-1:0]      dup_mask;
    logic [NUM_REQ-1:0]      eligible;
    logic [NUM_REQ-1:0]      grant;
    logic [PTR_W-1:0]        port_idx [NUM_WR_PORTS];
    logic [NUM_WR_PORTS-1:0] port_used;
    logic [PTR_W-1:0]        last_idx;
    logic                    any_grant;

    logic [NUM_WR_PORTS-1:0] we_q;
    logic [SRAM_INDEX-1:0]   addr_q [NUM_WR_PORTS];
    logic [SRAM_WIDTH-1:0]   data_q [NUM_WR_PORTS];

    // Split the flat request buses into per-requester slices.
    always_comb begin
        for (int r = 0; r < NUM_REQ; r++) begin
            req_addr[r] = req_addr_i[r*SRAM_INDEX +: SRAM_INDEX];
            req_data[r] = req_data_i[r*SRAM_WIDTH +: SRAM_WIDTH];
        end
    end

`ifdef RFWR_CONFLICT_CHECK_EN
    // Mask any valid requester whose address matches one earlier in scan order.
    always_comb begin
        dup_mask = '0;
        for (int r = 0; r < NUM_REQ; r++) begin
            for (int j = 0; j < NUM_REQ; j++) begin
                if ((j != r) && req_valid_i[j] && req_valid_i[r] &&
                    (req_addr[j] == req_addr[r]) &&
                    (((j - int'(ptr) + NUM_REQ) % NUM_REQ) < ((r - int'(ptr) + NUM_REQ) % NUM_REQ))) begin
                    dup_mask[r] = 1'b1;
                end
            end
        end
    end

    logic conflict_q;

    // Register a collision flag alongside the writes it affected.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            conflict_q <= 1'b0;
        end else begin
            conflict_q <= !stall_i && (|dup_mask);
        end
    end

    assign conflict_o = conflict_q;
`else
    assign dup_mask   = '0;
    assign conflict_o = 1'b0;
`endif

    assign eligible = req_valid_i & ~dup_mask;

    regwr_rr_select #(
        .NUM_REQ      (NUM_REQ),
        .NUM_WR_PORTS (NUM_WR_PORTS)
    ) u_sel (
        .valid     (eligible),
        .ptr       (ptr),
        .grant     (grant),
        .port_idx  (port_idx),
        .port_used (port_used),
        .last_idx  (last_idx),
        .any_grant (any_grant)
    );

    assign req_ready_o = (reset || stall_i) ? '0 : grant;

    // Capture granted writes into the port register and advance the pointer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr  <= '0;
            we_q <= '0;
            for (int k = 0; k < NUM_WR_PORTS; k++) begin
                addr_q[k] <= '0;
                data_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_WR_PORTS; k++) begin
                if (!stall_i && port_used[k]) begin
                    we_q[k]   <= 1'b1;
                    addr_q[k] <= req_addr[port_idx[k]];
                    data_q[k] <= req_data[port_idx[k]];
                end else begin
                    we_q[k]   <= 1'b0;
                    addr_q[k] <= '0;
                    data_q[k] <= '0;
                end
            end
            if (!stall_i && any_grant) begin
                ptr <= PTR_W'(wrap_inc(int'(last_idx), NUM_REQ));
            end
        end
    end

    // Flatten the per-port registers onto the register-file buses.
    always_comb begin
        we_o = we_q;
        for (int k = 0; k < NUM_WR_PORTS; k++) begin
            addrwr_o[k*SRAM_INDEX +: SRAM_INDEX] = addr_q[k];
            datawr_o[k*SRAM_WIDTH +: SRAM_WIDTH] = data_q[k];
        end
    end

endmodule
